// File: rtl/ser_scrambler_param.sv
// ---------------------------------------------------------------------------
// ser_scrambler_param
//
// Parallel-to-serial converter with a multiplicative (self-synchronising)
// scrambler on the interior bits of each word and per-word ASK/DPSK line
// coding. Words enter through a valid/ready handshake and leave MSB-first,
// one bit per clock, toward the transmitter modulator.
//
// Ports:
//   clk          bit clock, rising-edge active
//   rst          asynchronous active-high reset
//   word_in      parallel word (bit WORD_W-1 sent first)
//   word_valid   word_in is valid
//   word_ready   combinational: a word is accepted on this edge if valid
//   scr_en       scramble interior bits of the word (sampled at accept)
//   dpsk_en      1 = DPSK, 0 = ASK for the word (sampled at accept)
//   ser_out      registered serial line bit
//   ser_valid    ser_out carries a word bit this cycle
//   frame_start  ser_out is the first bit of a word
// ---------------------------------------------------------------------------
module ser_scrambler_param #(
  parameter int WORD_W     = 12,
  parameter int START_BITS = 1,
  parameter int STOP_BITS  = 1,
  parameter int LFSR_W     = 23,
  parameter int TAP_A      = 3,
  parameter int TAP_B      = 22,
  parameter logic [LFSR_W-1:0] SEED = {{(LFSR_W-1){1'b0}}, 1'b1}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  input  logic              scr_en,
  input  logic              dpsk_en,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              frame_start
);

  // Refuse to build with framing that leaves no interior or with bad taps.
  if ((START_BITS + STOP_BITS >= WORD_W) || (TAP_A >= TAP_B) || (TAP_B >= LFSR_W)) begin : g_bad_params
    $error("ser_scrambler_param: illegal parameter set");
  end

  // Counter is wide enough to hold WORD_W itself (used as a bound below).
  localparam int CW = $clog2(WORD_W + 1);
  localparam logic [CW-1:0] K_LAST      = CW'(WORD_W - 1);
  localparam logic [CW-1:0] K_INT_FIRST = CW'(START_BITS);
  localparam logic [CW-1:0] K_INT_END   = CW'(WORD_W - STOP_BITS);

  typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t              state, state_next;
  logic [WORD_W-1:0]   shreg, shreg_next;
  logic [CW-1:0]       k, k_next;
  logic [LFSR_W-1:0]   lfsr, lfsr_next;
  logic                scr_q, scr_next;
  logic                dpsk_q, dpsk_next;
  logic                out_next, valid_next, fs_next;
  logic                accept, interior, d, s;

  assign word_ready = (state == IDLE) || ((state == SHIFT) && (k == K_LAST));
  assign accept     = word_valid && word_ready;

  // Next-state and datapath: shift, scramble, line-code, handshake.
  always_comb begin
    state_next = state;
    shreg_next = shreg;
    k_next     = k;
    lfsr_next  = lfsr;
    scr_next   = scr_q;
    dpsk_next  = dpsk_q;
    out_next   = ser_out;
    valid_next = 1'b0;
    fs_next    = 1'b0;
    interior   = 1'b0;
    d          = 1'b0;
    s          = 1'b0;

    case (state)
      IDLE: begin
        // DPSK idles without a transition; ASK idles at 0.
        if (dpsk_q) begin
          out_next = ser_out;
        end else begin
          out_next = 1'b0;
        end
      end
      SHIFT: begin
        d          = shreg[WORD_W-1];
        shreg_next = {shreg[WORD_W-2:0], 1'b0};
        interior   = (k >= K_INT_FIRST) && (k < K_INT_END);
        // Multiplicative scrambler: the scrambled bit itself feeds the lfsr.
        if (interior && scr_q) begin
          s         = d ^ lfsr[TAP_A] ^ lfsr[TAP_B];
          lfsr_next = {lfsr[LFSR_W-2:0], s};
        end else begin
          s = d;
        end
        out_next   = dpsk_q ? (s ^ ser_out) : s;
        valid_next = 1'b1;
        fs_next    = (k == '0);
        if (k == K_LAST) begin
          state_next = IDLE;
          k_next     = '0;
        end else begin
          k_next = k + CW'(1);
        end
      end
      default: begin
        state_next = IDLE;
        k_next     = '0;
      end
    endcase

    // An accept on the last bit overrides the return to IDLE (no gap).
    if (accept) begin
      shreg_next = word_in;
      scr_next   = scr_en;
      dpsk_next  = dpsk_en;
      k_next     = '0;
      state_next = SHIFT;
    end else begin
      state_next = state_next;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      shreg       <= '0;
      k           <= '0;
      lfsr        <= SEED;
      scr_q       <= 1'b0;
      dpsk_q      <= 1'b0;
      ser_out     <= 1'b0;
      ser_valid   <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      state       <= state_next;
      shreg       <= shreg_next;
      k           <= k_next;
      lfsr        <= lfsr_next;
      scr_q       <= scr_next;
      dpsk_q      <= dpsk_next;
      ser_out     <= out_next;
      ser_valid   <= valid_next;
      frame_start <= fs_next;
    end
  end

endmodule

// File: tb/tb_ser_scrambler_param.sv
// ---------------------------------------------------------------------------
// Self-checking bench for ser_scrambler_param. A driver pushes accepted words
// into a queue; a monitor expands each word into expected line bits with a
// behavioural model and compares them as the DUT emits them. A second
// instance covers a 16-bit word with two framing bits at each end.
// ---------------------------------------------------------------------------
module tb_ser_scrambler_param;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] word_in = 12'h000;
  logic        word_valid = 1'b0;
  logic        scr_en = 1'b0;
  logic        dpsk_en = 1'b0;
  logic        word_ready, ser_out, ser_valid, frame_start;

  logic [15:0] w16 = 16'h0000;
  logic        v16 = 1'b0;
  logic        scr16 = 1'b1;
  logic        dpsk16 = 1'b0;
  logic        r16, o16, sv16, fs16;

  always #5 clk = ~clk;

  ser_scrambler_param dut (
    .clk(clk), .rst(rst), .word_in(word_in), .word_valid(word_valid),
    .word_ready(word_ready), .scr_en(scr_en), .dpsk_en(dpsk_en),
    .ser_out(ser_out), .ser_valid(ser_valid), .frame_start(frame_start)
  );

  ser_scrambler_param #(.WORD_W(16), .START_BITS(2), .STOP_BITS(2)) dut16 (
    .clk(clk), .rst(rst), .word_in(w16), .word_valid(v16),
    .word_ready(r16), .scr_en(scr16), .dpsk_en(dpsk16),
    .ser_out(o16), .ser_valid(sv16), .frame_start(fs16)
  );

  typedef struct { logic [11:0] w; logic scr; logic dpsk; } word_t;
  typedef struct { logic b; logic fs; logic dpsk; } exp_t;

  word_t wq[$];
  exp_t  bq[$];

  int          errors = 0;
  int          checks = 0;
  logic [22:0] m_lfsr = 23'h000001;
  logic        m_line = 1'b0;
  logic        m_dpsk_last = 1'b0;
  logic [31:0] obs = 32'h0;
  int          run = 0;
  int          last_run = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Behavioural reference: returns the line bits of a word MSB-first.
  task automatic model_word(input logic [31:0] w, input int ww, input int sb, input int eb,
                            input logic scr, input logic dpsk,
                            input logic [22:0] lf_in, input logic line_in,
                            output logic [22:0] lf_out, output logic [31:0] bits);
    logic [22:0] lf;
    logic line, d, s;
    lf = lf_in;
    line = line_in;
    bits = 32'h0;
    for (int k = 0; k < ww; k++) begin
      d = w[ww-1-k];
      if (scr && k >= sb && k < ww - eb) begin
        s = d ^ lf[3] ^ lf[22];
        lf = {lf[21:0], s};
      end else begin
        s = d;
      end
      line = dpsk ? (s ^ line) : s;
      bits[ww-1-k] = line;
    end
    lf_out = lf;
  endtask

  // Monitor: sample #1 after each rising edge.
  initial begin
    word_t       wt;
    exp_t        e;
    logic [31:0] bits;
    logic [22:0] nl;
    logic        idle_exp;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        if (ser_valid) begin
          if (bq.size() == 0 && wq.size() != 0) begin
            wt = wq.pop_front();
            model_word({20'h0, wt.w}, 12, 1, 1, wt.scr, wt.dpsk, m_lfsr, m_line, nl, bits);
            m_lfsr = nl;
            for (int i = 11; i >= 0; i--) bq.push_back('{b: bits[i], fs: (i == 11), dpsk: wt.dpsk});
          end
          if (bq.size() == 0) begin
            check("unexpected_bit", 32'd1, 32'd0);
          end else begin
            e = bq.pop_front();
            check("ser_out", {31'h0, ser_out}, {31'h0, e.b});
            check("frame_start", {31'h0, frame_start}, {31'h0, e.fs});
            m_line = e.b;
            m_dpsk_last = e.dpsk;
          end
          obs = {obs[30:0], ser_out};
          run++;
        end else begin
          check("bit_gap", bq.size(), 32'd0);
          idle_exp = m_dpsk_last ? m_line : 1'b0;
          check("idle_out", {31'h0, ser_out}, {31'h0, idle_exp});
          check("idle_fs", {31'h0, frame_start}, 32'h0);
          m_line = idle_exp;
          if (run != 0) last_run = run;
          run = 0;
        end
      end
    end
  end

  // Reset both DUTs and the model; checks the reset state while rst is high.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    word_valid = 1'b0;
    v16 = 1'b0;
    wq.delete();
    bq.delete();
    m_lfsr = 23'h000001;
    m_line = 1'b0;
    m_dpsk_last = 1'b0;
    run = 0;
    last_run = 0;
    #1;
    check("rst_ser_out", {31'h0, ser_out}, 32'h0);
    check("rst_ser_valid", {31'h0, ser_valid}, 32'h0);
    check("rst_frame_start", {31'h0, frame_start}, 32'h0);
    check("rst_word_ready", {31'h0, word_ready}, 32'h1);
    check("rst_lfsr", {9'h0, dut.lfsr}, 32'h000001);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Present a word (called at a negedge); returns at the negedge after accept.
  task automatic send(input logic [11:0] w, input logic scr, input logic dpsk);
    int n = 0;
    word_in = w;
    scr_en = scr;
    dpsk_en = dpsk;
    word_valid = 1'b1;
    while (!word_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!word_ready) begin
      check("ready_timeout", 32'd0, 32'd1);
    end else begin
      wq.push_back('{w: w, scr: scr, dpsk: dpsk});
    end
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    word_valid = 1'b0;
    while ((wq.size() != 0 || bq.size() != 0 || ser_valid) && n < 80) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", {31'h0, (n < 80)}, 32'h1);
  endtask

  initial begin
    logic [31:0] bits16;
    logic [22:0] lf16;
    logic [15:0] got16;

    // 1: all-ones word, scrambled ASK.
    do_reset();
    send(12'hFFF, 1'b1, 1'b0);
    drain();
    check("pattern_F0F", {20'h0, obs[11:0]}, 32'hF0F);
    check("lfsr_after_FFF", {9'h0, dut.lfsr}, 32'h000787);
    check("valid_run_12", last_run, 32'd12);

    // 2: unscrambled DPSK, then idle at 0.
    do_reset();
    send(12'hA00, 1'b0, 1'b1);
    drain();
    repeat (3) @(negedge clk);
    check("pattern_C00", {20'h0, obs[11:0]}, 32'hC00);
    check("lfsr_held", {9'h0, dut.lfsr}, 32'h000001);
    check("idle_valid", {31'h0, ser_valid}, 32'h0);

    // 3: back-to-back words with word_valid held high.
    do_reset();
    send(12'h5A3, 1'b1, 1'b0);
    for (int i = 0; i < 11; i++) begin
      check("ready_busy", {31'h0, word_ready}, 32'h0);
      @(negedge clk);
    end
    check("ready_last", {31'h0, word_ready}, 32'h1);
    send(12'h3C7, 1'b1, 1'b1);
    drain();
    check("valid_run_24", last_run, 32'd24);

    // 4: reset after 5 bits aborts the word; resend gives the same pattern.
    do_reset();
    send(12'hFFF, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    do_reset();
    send(12'hFFF, 1'b1, 1'b0);
    drain();
    check("pattern_F0F_again", {20'h0, obs[11:0]}, 32'hF0F);

    // 5: DPSK ending high holds through idle and references the next word.
    do_reset();
    send(12'h001, 1'b0, 1'b1);
    drain();
    repeat (3) @(negedge clk);
    check("dpsk_hold_out", {31'h0, ser_out}, 32'h1);
    check("dpsk_hold_valid", {31'h0, ser_valid}, 32'h0);
    send(12'h800, 1'b0, 1'b1);
    drain();
    check("dpsk_next_word", {20'h0, obs[11:0]}, 32'h000);

    // 6: random mix of modes with random gaps.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      send(12'($urandom), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
      if ($urandom_range(1, 0) == 1) begin
        word_valid = 1'b0;
        repeat ($urandom_range(14, 1)) @(negedge clk);
      end
    end
    drain();

    // 7: 16-bit instance with two framing bits at each end.
    do_reset();
    w16 = 16'hFFFF;
    v16 = 1'b1;
    check("w16_ready", {31'h0, r16}, 32'h1);
    @(negedge clk);
    v16 = 1'b0;
    got16 = 16'h0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      check("w16_valid", {31'h0, sv16}, 32'h1);
      check("w16_fs", {31'h0, fs16}, {31'h0, (i == 0)});
      got16 = {got16[14:0], o16};
    end
    model_word(32'h0000FFFF, 16, 2, 2, 1'b1, 1'b0, 23'h000001, 1'b0, lf16, bits16);
    check("w16_pattern", {16'h0, got16}, bits16);
    check("w16_framing", {28'h0, got16[15], got16[14], got16[1], got16[0]}, 32'hF);
    check("w16_lfsr", {9'h0, dut16.lfsr}, {9'h0, lf16});
    @(posedge clk);
    #1;
    check("w16_idle", {31'h0, sv16}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ser_scrambler_param.md
Name: ser_scrambler_param

Overview:
Parametrised successor to the 12-bit scrambling serializer. It accepts parallel words through a valid/ready handshake and shifts them out MSB-first, one bit per clk. Interior bits pass through a multiplicative (self-synchronising) scrambler; the framing bits at the MSB and LSB ends are sent unscrambled. Line coding is selected per word: ASK (NRZ) or DPSK (differential). The block feeds the transmitter modulator.

Parameters:
WORD_W, 12, word width in bits (bit WORD_W-1 is transmitted first)
START_BITS, 1, number of leading (MSB-end) bits sent unscrambled
STOP_BITS, 1, number of trailing (LSB-end) bits sent unscrambled
LFSR_W, 23, scrambler register length
TAP_A, 3, first feedback tap index
TAP_B, 22, second feedback tap index
SEED, 23'h000001, scrambler value after reset (LFSR_W bits)

Ports:
clk  input  1  bit clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
word_in  input  WORD_W  parallel word to serialise
word_valid  input  1  word_in is valid
word_ready  output  1  block accepts a word on this edge
scr_en  input  1  scramble interior bits; sampled at accept
dpsk_en  input  1  1 = DPSK, 0 = ASK; sampled at accept
ser_out  output  1  registered serial line bit
ser_valid  output  1  ser_out carries a word bit this cycle
frame_start  output  1  ser_out is bit WORD_W-1 (first bit) of a word

Behaviour:
- Reset (async, rst=1): state=IDLE; shift register=0; bit counter=0; lfsr=SEED; ser_out=0; ser_valid=0; frame_start=0; latched scr_en and dpsk_en=0.
- Reset mid-word aborts the word immediately. No further bits of that word are emitted.
- States: IDLE, SHIFT. Bit counter k runs 0..WORD_W-1; k=0 is the MSB.
- word_ready is combinational: 1 when state=IDLE, or when state=SHIFT and k=WORD_W-1. It is 0 otherwise.
- Accept occurs when word_valid and word_ready are both 1 on an edge. At accept: load the shift register with word_in, latch scr_en and dpsk_en, set k=0, go to SHIFT.
- Latency: for a word accepted at edge N, bit k appears on ser_out after edge N+1+k. The last bit appears after edge N+WORD_W.
- Back-to-back: a word accepted while k=WORD_W-1 produces its bit 0 on the very next edge. There is no idle gap.
- On the final bit with no accept, the block returns to IDLE.
- Each SHIFT edge:
  - d = current MSB of the shift register; shift left, filling with 0.
  - Interior bit (START_BITS <= k < WORD_W-STOP_BITS) with scr_en latched 1: s = d ^ lfsr[TAP_A] ^ lfsr[TAP_B]. The lfsr shifts toward the MSB with lfsr[0] <= s.
  - Framing bit, or scr_en latched 0: s = d, and the lfsr holds.
  - ser_out <= dpsk ? (s ^ ser_out) : s.
  - ser_valid <= 1; frame_start <= (k==0).
- IDLE edge: ser_valid <= 0 and frame_start <= 0. In ASK, ser_out <= 0. In DPSK, ser_out holds its value (no transition).
- The lfsr is never reseeded except by rst, so scrambler state carries across words.
- Illegal parameter sets must be rejected at elaboration: START_BITS+STOP_BITS >= WORD_W, or TAP_A >= TAP_B, or TAP_B >= LFSR_W.
- word_in changing while word_ready=0 has no effect.

Test Plan:
- Default parameters, after reset, accept 12'hFFF with scr_en=1, dpsk_en=0 -> ser_out bits MSB-first = 12'hF0F. ser_valid is high for 12 cycles; frame_start is high on the first cycle only. lfsr afterwards = 23'h000787.
- After reset, accept 12'hA00 with scr_en=0, dpsk_en=1 -> ser_out = 12'hC00 pattern, then holds 0 in IDLE. ser_valid then drops to 0. lfsr stays 23'h000001.
- Two words presented with word_valid held high -> second accepted at k=11, giving 24 consecutive ser_valid cycles. frame_start pulses at cycles 1 and 13. word_ready is low for cycles 1-10 of each word.
- Assert rst after 5 bits of 12'hFFF -> ser_out, ser_valid and word_ready-gating cleared immediately. Re-sending 12'hFFF yields 12'hF0F again.
- DPSK with ser_out=1 at the end of a word, then 3 idle cycles -> ser_out stays 1, ser_valid=0. The next word's first bit is XORed with 1.
- WORD_W=16, START_BITS=2, STOP_BITS=2, word 16'hFFFF with scr_en=1 -> bits 15,14,1,0 are 1 unscrambled, and the lfsr advances exactly 12 times (checked against a reference model).
